imem_loader: RTL and testbench

Boot-time instruction memory loader for the multi-cycle processor. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them sequentially into instruction memory from word 0. Holds the processor core in reset until the image is fully loaded, and releases the core into normal fetch on completion. It is the hardware writer of the same instruction memory that the fetch stage reads.

---
 rtl/imem_loader.sv | 151 +++++++++++++++
 tb/tb_imem_loader.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: byte stream -> little-endian words -> imem, core held in reset until done.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    localparam int unsigned CNT_W = 16;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_HDR0, S_HDR1, S_DATA, S_CSUM, S_DONE, S_ERROR} state_e;
    localparam state_e S_TAIL = S_CSUM;
`else
    typedef enum logic [2:0] {S_HDR0, S_HDR1, S_DATA, S_DONE, S_ERROR} state_e;
    localparam state_e S_TAIL = S_DONE;
`endif

    state_e             state_q;
    logic [1:0]         lane_q;
    logic [23:0]        word_q;
    logic [7:0]         hdr_lo_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]  waddr_q;
    logic               in_ready_q;
    logic               imem_we_q;
    logic [ADDR_W-1:0]  imem_addr_q;
    logic [31:0]        imem_wdata_q;
    logic               cpu_reset_q;
    logic               done_q;
    logic               error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         sum_q;
`endif

    logic               take;
    logic [CNT_W-1:0]   count_d;
    logic [31:0]        word_d;
    logic               last_word;

    function automatic logic accepts(input state_e s);
        return (s != S_DONE) && (s != S_ERROR);
    endfunction

    always_comb begin
        take      = in_valid && in_ready_q;
        count_d   = {in_data, hdr_lo_q};
        word_d    = {in_data, word_q};
        last_word = (cnt_q == CNT_W'(1));
    end

    // Bytes enter at the top of word_q so the 4th byte completes a little-endian word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_HDR0;
            lane_q       <= '0;
            word_q       <= '0;
            hdr_lo_q     <= '0;
            cnt_q        <= '0;
            waddr_q      <= '0;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            imem_we_q   <= 1'b0;
            done_q      <= (state_q == S_DONE);
            cpu_reset_q <= (state_q != S_DONE);
            in_ready_q  <= accepts(state_q);
            if (take) begin
                unique case (state_q)
                    S_HDR0: begin
                        hdr_lo_q <= in_data;
                        state_q  <= S_HDR1;
                    end
                    S_HDR1: begin
                        if (count_d > CNT_W'(DEPTH)) begin
                            state_q    <= S_ERROR;
                            error_q    <= 1'b1;
                            in_ready_q <= 1'b0;
                        end else if (count_d == '0) begin
                            state_q    <= S_TAIL;
                            in_ready_q <= accepts(S_TAIL);
                        end else begin
                            cnt_q   <= count_d;
                            state_q <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        lane_q <= lane_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_q  <= sum_q + in_data;
`endif
                        if (lane_q == 2'd3) begin
                            imem_we_q    <= 1'b1;
                            imem_addr_q  <= waddr_q;
                            imem_wdata_q <= word_d;
                            if (last_word) begin
                                state_q    <= S_TAIL;
                                in_ready_q <= accepts(S_TAIL);
                            end else begin
                                waddr_q <= waddr_q + ADDR_W'(1);
                                cnt_q   <= cnt_q - CNT_W'(1);
                            end
                        end else begin
                            word_q <= word_d[31:8];
                        end
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    S_CSUM: begin
                        in_ready_q <= 1'b0;
                        if (in_data == sum_q) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed timing sequences, header table, randomized images vs. a stream model.
module tb_imem_loader;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] n;
        int          gap;
        bit          bad_csum;
        bit          exp_done;
        bit          exp_err;
        int          exp_writes;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_writes = 0;
    int          gap_mode = 0;
    bit          tog = 1'b0;
    bit          prev_we = 1'b0;
    bit          m_done;
    bit          m_err;
    logic [7:0]  img[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s @%0t", name, $time);
    endtask

    // Write scoreboard: every strobe must match the next expected (addr, data) and last one cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            n_writes++;
            check("we_one_cycle", 32'(prev_we), 32'd0);
            if (exp_addr_q.size() == 0) begin
                fail("unexpected_write");
            end else begin
                check("write_addr", 32'(imem_addr), exp_addr_q.pop_front());
                check("write_data", imem_wdata, exp_data_q.pop_front());
            end
        end
        prev_we = (imem_we === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: derive writes and final outcome straight from the byte stream rules.
    task automatic model_expect();
        int n;
        n = int'(img[0]) + 256 * int'(img[1]);
        exp_addr_q.delete();
        exp_data_q.delete();
        m_done = 1'b0;
        m_err  = 1'b0;
        if (n > int'(DEPTH)) begin
            m_err = 1'b1;
        end else begin
            for (int w = 0; w < n; w++) begin
                exp_addr_q.push_back(32'(w));
                exp_data_q.push_back({img[2+4*w+3], img[2+4*w+2], img[2+4*w+1], img[2+4*w]});
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            begin
                int s;
                s = 0;
                for (int i = 2; i < 2 + 4 * n; i++) s = s + int'(img[i]);
                if (int'(img[2+4*n]) == s % 256) m_done = 1'b1;
                else                             m_err  = 1'b1;
            end
`else
            m_done = 1'b1;
`endif
        end
    endtask

    task automatic append_csum();
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] s;
        s = 8'h00;
        for (int i = 2; i < img.size(); i++) s = s + img[i];
        img.push_back(s);
`endif
    endtask

    task automatic build_image(input logic [15:0] n);
        img.delete();
        img.push_back(n[7:0]);
        img.push_back(n[15:8]);
        if (int'(n) <= int'(DEPTH)) begin
            for (int i = 0; i < 4 * int'(n); i++) img.push_back(8'($urandom));
            append_csum();
        end
    endtask

    task automatic build_fixed();
        img = {8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
        append_csum();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
        n_writes = 0;
        reset = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        bit took;
        bit offer;
        guard = 0;
        took  = 1'b0;
        while (!took && guard < 64) begin
            case (gap_mode)
                0:       offer = 1'b1;
                1:       begin tog = !tog; offer = tog; end
                default: offer = ($urandom_range(0, 1) == 1);
            endcase
            in_valid = offer;
            in_data  = offer ? b : 8'($urandom);
            took     = offer && (in_ready === 1'b1);
            tick();
            guard++;
        end
        in_valid = 1'b0;
        if (!took) fail("accept_timeout");
    endtask

    task automatic send_all();
        for (int i = 0; i < img.size(); i++) send_byte(img[i]);
    endtask

    task automatic finish_case(input bit exp_done, input bit exp_err, input int exp_writes);
        tick();
        check("end_done", 32'(done), 32'(exp_done));
        check("end_error", 32'(error), 32'(exp_err));
        check("end_cpu_reset", 32'(cpu_reset), 32'(!exp_done));
        check("end_in_ready", 32'(in_ready), 32'd0);
        check("end_writes", 32'(n_writes), 32'(exp_writes));
        check("end_pending", 32'(exp_addr_q.size()), 32'd0);
        if (exp_writes > 0) check("end_addr_held", 32'(imem_addr), 32'(exp_writes - 1));
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("terminal_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        check("terminal_done", 32'(done), 32'(exp_done));
        check("terminal_writes", 32'(n_writes), 32'(exp_writes));
    endtask

    initial begin
        vec_t vecs[$];
        int unsigned rn;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        vecs.push_back('{16'd0,      0, 1'b0, 1'b1, 1'b0, 0});
        vecs.push_back('{16'd1,      0, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{16'd2,      1, 1'b0, 1'b1, 1'b0, 2});
        vecs.push_back('{16'd7,      2, 1'b0, 1'b1, 1'b0, 7});
        vecs.push_back('{16'd64,     2, 1'b0, 1'b1, 1'b0, 64});
        vecs.push_back('{16'd65,     0, 1'b0, 1'b0, 1'b1, 0});
        vecs.push_back('{16'h0100,   0, 1'b0, 1'b0, 1'b1, 0});
        vecs.push_back('{16'hFFFF,   2, 1'b0, 1'b0, 1'b1, 0});
`ifdef IMEM_LOADER_CHECKSUM_EN
        vecs.push_back('{16'd3,      0, 1'b1, 1'b0, 1'b1, 3});
`endif

        // Back-to-back N=2 image with exact write and done timing.
        do_reset();
        build_fixed();
        model_expect();
        gap_mode = 0;
        for (int i = 0; i < 6; i++) send_byte(img[i]);
        check("w0_we", 32'(imem_we), 32'd1);
        check("w0_addr", 32'(imem_addr), 32'd0);
        check("w0_data", imem_wdata, 32'h00100013);
        tick();
        check("w0_we_low", 32'(imem_we), 32'd0);
        check("w0_data_held", imem_wdata, 32'h00100013);
        for (int i = 6; i < 10; i++) send_byte(img[i]);
        check("w1_we", 32'(imem_we), 32'd1);
        check("w1_addr", 32'(imem_addr), 32'd1);
        check("w1_data", imem_wdata, 32'h00200093);
        check("w1_done_low", 32'(done), 32'd0);
        check("w1_cpu_reset", 32'(cpu_reset), 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("w1_in_ready", 32'(in_ready), 32'd1);
        send_byte(img[10]);
        check("csum_done_low", 32'(done), 32'd0);
`else
        check("w1_in_ready", 32'(in_ready), 32'd0);
`endif
        tick();
        check("fix_done", 32'(done), 32'd1);
        check("fix_cpu_reset", 32'(cpu_reset), 32'd0);
        check("fix_in_ready", 32'(in_ready), 32'd0);
        check("fix_writes", 32'(n_writes), 32'd2);

        // Same image with in_valid toggling every other cycle.
        do_reset();
        build_fixed();
        model_expect();
        gap_mode = 1;
        send_all();
        finish_case(1'b1, 1'b0, 2);

        // Oversized header: error on the edge accepting the high count byte.
        do_reset();
        img = {8'h41, 8'h00};
        model_expect();
        gap_mode = 0;
        send_byte(img[0]);
        send_byte(img[1]);
        check("ovf_error_now", 32'(error), 32'd1);
        check("ovf_in_ready", 32'(in_ready), 32'd0);
        check("ovf_cpu_reset", 32'(cpu_reset), 32'd1);
        finish_case(1'b0, 1'b1, 0);

        // Reset after 6 bytes, then full reload rewrites word 0.
        do_reset();
        build_fixed();
        model_expect();
        gap_mode = 0;
        for (int i = 0; i < 6; i++) send_byte(img[i]);
        do_reset();
        model_expect();
        send_all();
        finish_case(1'b1, 1'b0, 2);

        foreach (vecs[k]) begin
            do_reset();
            build_image(vecs[k].n);
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (vecs[k].bad_csum) img[img.size()-1] = img[img.size()-1] + 8'h01;
`endif
            model_expect();
            gap_mode = vecs[k].gap;
            send_all();
            finish_case(vecs[k].exp_done, vecs[k].exp_err, vecs[k].exp_writes);
        end

        for (int r = 0; r < 6; r++) begin
            do_reset();
            rn = $urandom_range(1, DEPTH);
            build_image(16'(rn));
            model_expect();
            gap_mode = 2;
            send_all();
            finish_case(m_done, m_err, int'(rn));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
